// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and helpers for the round-robin mux arbiter
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after last owner
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan farthest-first so the nearest set bit after last is written last and wins.
  always_comb begin
    winner = last;
    idx    = '0;
    any    = |req;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last + SEL_W'(i);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner of the 4:1 mux select with hold limit and dead cycle
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             expired
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] last, last_n;
  logic [N_REQ-1:0] gnt_n;
  logic [SEL_W-1:0] sel_n;
  logic             expired_n;
  logic [SEL_W-1:0] winner;
  logic             any;

  rr_pick u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= SEL_W'(N_REQ - 1);
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      last    <= last_n;
      gnt     <= gnt_n;
      sel     <= sel_n;
      valid   <= |gnt_n;
      expired <= expired_n;
    end
  end

  // Sel only moves on a new grant, so the mux never switches under a live owner.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_n    = last;
    gnt_n     = gnt;
    sel_n     = sel;
    expired_n = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (enable && any) begin
          state_n = GRANT;
          gnt_n   = onehot(winner);
          sel_n   = winner;
          cnt_n   = CNT_W'(1);
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
      GRANT: begin
        if (!enable || !req[sel]) begin
          state_n = GAP;
          gnt_n   = '0;
          last_n  = sel;
        end else if (cnt == CNT_W'(MAX_HOLD)) begin
          state_n   = GAP;
          gnt_n     = '0;
          last_n    = sel;
          expired_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] req;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       valid_a, valid_b;
  logic       expired_a, expired_b;

  int n_pass;
  int n_total;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .req     (req),
    .gnt     (gnt_a),
    .sel     (sel_a),
    .valid   (valid_a),
    .expired (expired_a)
  );

  mux_rr_arbiter #(.MAX_HOLD(2), .CNT_W(4)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .req     (req),
    .gnt     (gnt_b),
    .sel     (sel_b),
    .valid   (valid_b),
    .expired (expired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic e);
    chk({tag, ".gnt"}, gnt_a, g);
    chk({tag, ".sel"}, {2'b00, sel_a}, {2'b00, s});
    chk({tag, ".valid"}, {3'b000, valid_a}, {3'b000, |g});
    chk({tag, ".expired"}, {3'b000, expired_a}, {3'b000, e});
  endtask

  logic [3:0] exp_g;
  logic [1:0] exp_s;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    enable  = 1'b1;
    req     = 4'b1111;

    // 1: reset state before any clock edge, then first grant to requester 0
    #3;
    chk_a("rst", 4'b0000, 2'd0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_a("rst_first", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_a("rst_rel", 4'b0000, 2'd0, 1'b0);

    // 2: single request held three edges, then dropped
    req = 4'b0100;
    step();
    chk_a("single_1", 4'b0100, 2'd2, 1'b0);
    step();
    chk_a("single_2", 4'b0100, 2'd2, 1'b0);
    step();
    chk_a("single_3", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    step();
    chk_a("single_rel", 4'b0000, 2'd2, 1'b0);

    // 4: wrap priority after last=0
    req = 4'b0001;
    step();
    chk_a("wrap_g0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_a("wrap_gap0", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    step();
    chk_a("wrap_g3", 4'b1000, 2'd3, 1'b0);
    req = 4'b0001;
    step();
    chk_a("wrap_gap3", 4'b0000, 2'd3, 1'b0);
    step();
    chk_a("wrap_g0b", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_a("wrap_idle", 4'b0000, 2'd0, 1'b0);

    // 5: enable drop during grant to requester 1
    req = 4'b0010;
    step();
    chk_a("en_g1", 4'b0010, 2'd1, 1'b0);
    enable = 1'b0;
    step();
    chk_a("en_drop", 4'b0000, 2'd1, 1'b0);
    req = 4'b1111;
    step();
    chk_a("en_block1", 4'b0000, 2'd1, 1'b0);
    step();
    chk_a("en_block2", 4'b0000, 2'd1, 1'b0);
    enable = 1'b1;
    step();
    chk_a("en_g2", 4'b0100, 2'd2, 1'b0);

    // 6: async reset between edges while requester 2 owns the mux
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("areset", 4'b0000, 2'd0, 1'b0);
    req = 4'b0110;
    step();
    rst_n = 1'b1;
    step();
    chk_a("areset_g1", 4'b0010, 2'd1, 1'b0);

    // 3: all requesting with MAX_HOLD=2 on the second instance
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_s = 2'(k % 4);
      exp_g = 4'b0001 << exp_s;
      for (int h = 0; h < 2; h++) begin
        step();
        chk($sformatf("hold_g%0d_%0d.gnt", k, h), gnt_b, exp_g);
        chk($sformatf("hold_g%0d_%0d.sel", k, h), {2'b00, sel_b}, {2'b00, exp_s});
        chk($sformatf("hold_g%0d_%0d.exp", k, h), {3'b000, expired_b}, 4'd0);
      end
      if (k < 4) begin
        step();
        chk($sformatf("gap%0d.gnt", k), gnt_b, 4'b0000);
        chk($sformatf("gap%0d.sel", k), {2'b00, sel_b}, {2'b00, exp_s});
        chk($sformatf("gap%0d.valid", k), {3'b000, valid_b}, 4'd0);
        chk($sformatf("gap%0d.exp", k), {3'b000, expired_b}, 4'd1);
      end
    end
    step();
    chk("gap_last.exp", {3'b000, expired_b}, 4'd1);
    step();
    chk("regrant_after.exp", {3'b000, expired_b}, 4'd0);
    chk("regrant_after.gnt", gnt_b, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
